multi_cycle_control_fsm: RTL

Main sequencer for the multi-cycle RV32I core. Steps each instruction through IF/ID/EX/MEM/WB states. Drives the write strobes and mux selects for the PC, IR, memory, ALU and register file, including the register file's write_enable.

---
 rtl/multi_cycle_control_fsm.sv | 126 ++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_fsm.sv
// multi_cycle_control_fsm: IF/ID/EX/MEM/WB sequencer with ECALL halt and retired-instruction counter
module multi_cycle_control_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             halt_cond,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       rd_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             is_ecall,
    output logic             is_halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    logic [2:0]       state_q, state_d;
    logic             is_halted_q, is_halted_d;
    logic [CNT_W-1:0] retired_count_q, retired_count_d;
    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_sys, is_known;
    assign is_r      = opcode == OP_R;
    assign is_i      = opcode == OP_I;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_sys    = opcode == OP_ECALL;
    assign is_known  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;
    always_comb begin
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        rd_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        is_ecall    = 1'b0;
        state_d     = RESET_STATE;
        is_halted_d = 1'b0;
        if (!reset) begin
            is_halted_d = is_halted_q;
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    state_d  = mem_ready ? S_ID : S_IF;
                end
                S_ID: begin
                    is_ecall = is_sys;
                    if (is_sys && halt_cond) begin
                        state_d     = S_HALT;
                        is_halted_d = 1'b1;
                    end else if (!is_sys && is_known) begin
                        state_d = S_EX;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_IF;
                    end
                end
                S_EX: begin
                    alu_src_a = !is_jal;
                    alu_src_b = (is_r || is_branch) ? 2'b00 : 2'b10;
                    alu_op    = (is_r || is_i) ? 2'b10 : is_branch ? 2'b01 : 2'b00;
                    pc_write  = is_branch;
                    pc_source = (is_branch && bcond) ? 2'b01 : 2'b00;
                    state_d   = is_branch ? S_IF : (is_load || is_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = is_load;
                    mem_write = is_store;
                    pc_write  = mem_ready && !is_load;
                    state_d   = !mem_ready ? S_MEM : is_load ? S_WB : S_IF;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    rd_src    = is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
                    pc_source = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                    state_d   = S_IF;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IF;
            endcase
        end
        retired_count_d = reset ? '0 : retired_count_q + CNT_W'(pc_write);
    end
    always_ff @(posedge clk) begin
        state_q         <= state_d;
        is_halted_q     <= is_halted_d;
        retired_count_q <= retired_count_d;
    end
    assign state         = state_q;
    assign is_halted     = is_halted_q;
    assign retired_count = retired_count_q;
endmodule
